// File: rtl/pipe_mux_nto1.sv
// pipe_mux_nto1
// Registered N-to-1 datapath multiplexer stage with a 1-entry skid buffer.
// Picks one of NUM_PORTS words per transfer and hands it across a pipeline
// stage boundary that may be stalled by the consumer.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (highest priority)
//   flush      drops the main word, the skid word and any same-cycle accept
//   in_data    NUM_PORTS flattened words, port k at [k*WIDTH +: WIDTH]
//   in_sel     port select, sampled together with in_data
//   in_valid   producer offers a word
//   in_ready   block can take a word this cycle (registered)
//   out_data   registered selected word
//   out_valid  out_data holds a word
//   out_ready  consumer takes out_data this cycle
//   sel_err    sticky: some accepted transfer used in_sel >= NUM_PORTS
//
// Handshake: a word moves on a rising edge when valid && ready are both high
// on that interface. Once out_valid is high, out_data stays bit-stable until
// out_ready is seen. in_ready = !skid_valid, so it is a pure register output
// with no combinational path from out_ready.

module pipe_mux_nto1 #(
  parameter int WIDTH     = 32,
  parameter int NUM_PORTS = 3,
  parameter int SEL_W     = $clog2(NUM_PORTS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [NUM_PORTS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]           in_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       sel_err
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic [WIDTH-1:0] sel_data;
  logic             sel_oor;
  logic             accept;
  logic             main_free;

  // Out-of-range selects fall back to port 0; only legal ports are ever
  // indexed, so nothing beyond the flattened bus is read.
  always_comb begin
    sel_data = in_data[0 +: WIDTH];
    for (int k = 1; k < NUM_PORTS; k++) begin
      if (in_sel == SEL_W'(k)) sel_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  // One extra bit so the compare works even when NUM_PORTS is a power of two
  // (in which case it can never be true).
  assign sel_oor   = ({1'b0, in_sel} >= (SEL_W+1)'(NUM_PORTS));

  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  assign main_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      sel_err    <= 1'b0;
    end else if (flush) begin
      // out_data is left as is; it is meaningless while out_valid is low.
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      if (accept && sel_oor) sel_err <= 1'b1;

      if (main_free) begin
        // The skid word is older than anything arriving now, so it goes
        // first. accept cannot coincide with skid_valid (in_ready is low).
        if (skid_valid) begin
          out_data   <= skid_data;
          out_valid  <= 1'b1;
          skid_valid <= 1'b0;
        end else if (accept) begin
          out_data  <= sel_data;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        // Main is stalled: park the new word so in_ready could stay
        // registered for this cycle.
        skid_data  <= sel_data;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_mux_nto1.sv
// Directed bench for pipe_mux_nto1: a 4-port instance for datapath, skid,
// flush and reset behaviour, and a 3-port instance for out-of-range select.
module tb_pipe_mux_nto1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-port instance
  logic [4*32-1:0] in_data4;
  logic [1:0]      in_sel4;
  logic            in_valid4, in_ready4, out_valid4, out_ready4, flush4, sel_err4;
  logic [31:0]     out_data4;

  // 3-port instance
  logic [3*32-1:0] in_data3;
  logic [1:0]      in_sel3;
  logic            in_valid3, in_ready3, out_valid3, out_ready3, flush3, sel_err3;
  logic [31:0]     out_data3;

  pipe_mux_nto1 #(.WIDTH(32), .NUM_PORTS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush4),
    .in_data(in_data4), .in_sel(in_sel4), .in_valid(in_valid4), .in_ready(in_ready4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sel_err(sel_err4)
  );

  pipe_mux_nto1 #(.WIDTH(32), .NUM_PORTS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush3),
    .in_data(in_data3), .in_sel(in_sel3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .sel_err(sel_err3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one edge; outputs are sampled 1 ns after it and new inputs are
  // applied right after sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  stream_sel [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
  logic [31:0] stream_exp [4] = '{32'h11, 32'h22, 32'h44, 32'h33};

  initial begin
    rst_n = 1'b0;
    in_data4 = {32'h44, 32'h33, 32'h22, 32'h11};
    in_sel4 = '0; in_valid4 = 1'b0; out_ready4 = 1'b1; flush4 = 1'b0;
    in_data3 = {32'hC, 32'hB, 32'hA};
    in_sel3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b1; flush3 = 1'b0;

    step(); step();
    check("rst_out_valid", 32'(out_valid4), 32'd0);
    check("rst_out_data",  out_data4,       32'h0);
    check("rst_in_ready",  32'(in_ready4),  32'd1);
    check("rst_sel_err",   32'(sel_err4),   32'd0);
    check("rst3_in_ready", 32'(in_ready3),  32'd1);
    rst_n = 1'b1;

    // basic: one accept with sel 2
    in_valid4 = 1'b1; in_sel4 = 2'd2;
    step();
    check("basic_valid", 32'(out_valid4), 32'd1);
    check("basic_data",  out_data4,       32'h33);
    in_valid4 = 1'b0;
    step();
    check("basic_drained", 32'(out_valid4), 32'd0);

    // streaming at full rate
    in_valid4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel4 = stream_sel[i];
      step();
      check($sformatf("stream%0d_data", i),  out_data4,       stream_exp[i]);
      check($sformatf("stream%0d_valid", i), 32'(out_valid4), 32'd1);
      check($sformatf("stream%0d_ready", i), 32'(in_ready4),  32'd1);
    end
    in_valid4 = 1'b0;
    step();
    check("stream_idle", 32'(out_valid4), 32'd0);

    // backpressure: A into main, B into skid
    out_ready4 = 1'b0;
    in_valid4 = 1'b1; in_sel4 = 2'd0;
    step();
    check("bp_a_data",  out_data4,      32'h11);
    check("bp_a_ready", 32'(in_ready4), 32'd1);
    in_sel4 = 2'd1;
    step();
    check("bp_b_main",  out_data4,      32'h11);
    check("bp_b_ready", 32'(in_ready4), 32'd0);
    // C offered while full must not be taken
    in_sel4 = 2'd3;
    step();
    check("bp_hold_data",  out_data4,       32'h11);
    check("bp_hold_valid", 32'(out_valid4), 32'd1);
    check("bp_hold_ready", 32'(in_ready4),  32'd0);
    out_ready4 = 1'b1;
    step();
    check("bp_skid_data",  out_data4,      32'h22);
    check("bp_skid_ready", 32'(in_ready4), 32'd1);
    step();
    check("bp_c_data", out_data4, 32'h44);
    in_valid4 = 1'b0;
    step();
    check("bp_idle", 32'(out_valid4), 32'd0);

    // flush with main and skid full and an accept attempt
    out_ready4 = 1'b0;
    in_valid4 = 1'b1; in_sel4 = 2'd0;
    step();
    in_sel4 = 2'd1;
    step();
    check("fl_full_ready", 32'(in_ready4), 32'd0);
    flush4 = 1'b1; in_sel4 = 2'd2;
    step();
    check("fl_out_valid", 32'(out_valid4), 32'd0);
    check("fl_in_ready",  32'(in_ready4),  32'd1);
    check("fl_sel_err",   32'(sel_err4),   32'd0);
    flush4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b1;
    step();
    check("fl_no_ghost", 32'(out_valid4), 32'd0);

    // reset mid-operation, reset beats flush and accept
    out_ready4 = 1'b0;
    in_valid4 = 1'b1; in_sel4 = 2'd0;
    step();
    in_sel4 = 2'd1;
    step();
    rst_n = 1'b0; flush4 = 1'b1; in_sel4 = 2'd3;
    step();
    check("mrst_out_valid", 32'(out_valid4), 32'd0);
    check("mrst_out_data",  out_data4,       32'h0);
    check("mrst_in_ready",  32'(in_ready4),  32'd1);
    check("mrst_sel_err",   32'(sel_err4),   32'd0);
    rst_n = 1'b1; flush4 = 1'b0; out_ready4 = 1'b1; in_sel4 = 2'd1;
    step();
    check("mrst_first_valid", 32'(out_valid4), 32'd1);
    check("mrst_first_data",  out_data4,       32'h22);
    in_valid4 = 1'b0;
    step();
    check("mrst_idle",       32'(out_valid4), 32'd0);
    check("pow2_no_sel_err", 32'(sel_err4),   32'd0);

    // 3-port: legal select leaves sel_err clear
    in_valid3 = 1'b1; in_sel3 = 2'd0;
    step();
    check("oor_legal_data", out_data3,     32'hA);
    check("oor_legal_err",  32'(sel_err3), 32'd0);
    // out-of-range select defaults to port 0 and sets the sticky flag
    in_sel3 = 2'd3;
    step();
    check("oor_data", out_data3,     32'hA);
    check("oor_err",  32'(sel_err3), 32'd1);
    in_sel3 = 2'd1;
    step();
    check("oor_next_data", out_data3,     32'hB);
    check("oor_sticky1",   32'(sel_err3), 32'd1);
    in_sel3 = 2'd2;
    step();
    check("oor_next2_data", out_data3,     32'hC);
    check("oor_sticky2",    32'(sel_err3), 32'd1);
    in_valid3 = 1'b0;
    step();
    check("oor_sticky_idle", 32'(sel_err3), 32'd1);
    flush3 = 1'b1;
    step();
    check("oor_flush_err",   32'(sel_err3),   32'd0);
    check("oor_flush_valid", 32'(out_valid3), 32'd0);
    flush3 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_mux_nto1.md
Name: pipe_mux_nto1

Overview:
- Parametrised, registered N-to-1 datapath multiplexer stage. It is the successor to the fixed 3-input combinational operand mux.
- Used in the CPU pipeline wherever a selected operand or result must cross a stage boundary under stall.
- Selects one of NUM_PORTS words per transfer and registers it behind a valid/ready handshake.
- A 1-entry skid buffer gives full throughput with a registered in_ready path. Flush and a sticky out-of-range-select flag are also provided.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- NUM_PORTS, 3, number of input ports (2..16).
- SEL_W, $clog2(NUM_PORTS), select width. Derived; not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset. Sampled on the rising edge of clk.
- flush  input  1  drop all held and in-flight data (pipeline flush).
- in_data  input  NUM_PORTS*WIDTH  flattened ports; port k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  port select, sampled with in_data.
- in_valid  input  1  producer has a word to transfer.
- in_ready  output  1  block can accept a word this cycle.
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts out_data this cycle.
- sel_err  output  1  sticky flag: an accepted transfer had in_sel >= NUM_PORTS.

Behaviour:
- Select rule (combinational, internal):
  - in_sel < NUM_PORTS -> port[in_sel].
  - Otherwise -> port 0. This matches the legacy default-to-port0 rule.
- Input transfer ("accept") = in_valid && in_ready. Output transfer ("drain") = out_valid && out_ready.
- Storage: main register (out_data/out_valid) and skid register (skid_data/skid_valid).
- in_ready = !skid_valid. It depends on a register only; there is no combinational path from out_ready.
- Per rising edge, when rst_n=1 and flush=0:
  - Main empty, or drain: main loads skid if skid_valid, else the accepted word. If neither exists, out_valid goes to 0.
  - Skid valid and drain: skid empties into main. A new accept in the same cycle is impossible because in_ready=0.
  - Main full, no drain, accept: word goes to skid and skid_valid goes to 1.
  - Main full, no drain, no accept: hold. out_data must stay bit-stable while out_valid && !out_ready.
- Latency: 1 cycle from accept to out_valid when the block is empty. Throughput: 1 word/cycle while out_ready=1.
- Ordering: strict FIFO. A skid word always leaves before any later word.
- sel_err:
  - Set on the edge of any accept with in_sel >= NUM_PORTS.
  - Cleared only by reset or flush. Never set when NUM_PORTS is a power of two.
- flush=1 (rst_n=1), at the edge:
  - out_valid=0 and skid_valid=0. The accept in that cycle is dropped.
  - sel_err=0. out_data keeps its last value (don't-care).
  - in_ready=1 the next cycle.
- Reset (rst_n=0 at the edge), highest priority over flush and transfers:
  - out_valid=0, out_data=0, skid_valid=0, skid_data=0, sel_err=0. In_ready is therefore 1 after the reset edge.
  - Reset asserted mid-transfer discards both held words. No output is produced from them.
- Out-of-range port values are never read; no X is propagated.

Test Plan:
- Reset/basic: WIDTH=32, NUM_PORTS=4, ports={0x11,0x22,0x33,0x44}, out_ready=1, one accept with in_sel=2 -> next cycle out_valid=1, out_data=0x00000033. After reset: out_valid=0, out_data=0, in_ready=1, sel_err=0.
- Streaming: out_ready=1, in_sel sequence 0,1,3,2 on consecutive cycles -> out_data 0x11,0x22,0x44,0x33 on consecutive cycles; in_ready stays 1.
- Backpressure/skid:
  - Words A (sel0) then B (sel1) accepted, out_ready=0 -> out_data holds 0x11, skid holds 0x22, in_ready=0.
  - Raise out_ready -> 0x11, then 0x22 on consecutive cycles; in_ready returns to 1 the cycle after the skid drains.
- Out-of-range: NUM_PORTS=3, ports={0xA,0xB,0xC}, accept in_sel=3 -> out_data=0x0000000A, sel_err=1. It stays 1 across further valid transfers until flush.
- Flush: main and skid full, out_ready=0, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, sel_err=0. The flushed word never appears on out_data.
- Reset mid-operation: main and skid full, rst_n=0 for one edge with in_valid=1 and flush=1 -> all outputs at reset values. The first post-reset accept (sel1, 0x22) appears after 1 cycle.
